// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit FIFO.
// Optional feature macro: UART_FIFO_OVF_COUNT_EN (adds a saturating drop counter).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    ARM,
    HOLD
  } tx_fifo_state_t;

  localparam int UART_FRAME_SIZE_DEFAULT = 8;
  localparam int OVF_COUNT_W             = 16;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bus bundle between the UART receiver side, the FIFO, and the UART transmitter.
// With UART_FIFO_OVF_COUNT_EN defined the bundle also carries overflow_count.
interface uart_tx_fifo_if #(
  parameter int FRAME_SIZE = 8,
  parameter int DEPTH      = 16
);
  import uart_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  // Handshake: wr_en is a one-cycle strobe that carries wr_data; it is accepted
  // when not full or when a pop happens in the same cycle, otherwise dropped
  // and flagged. tx_start is a one-cycle launch pulse with tx_data stable from
  // that cycle until the next launch; tx_busy low is the only ready signal.
  logic [FRAME_SIZE-1:0] wr_data;
  logic                  wr_en;
  logic                  tx_busy;
  logic [FRAME_SIZE-1:0] tx_data;
  logic                  tx_start;
  logic [ADDR_W:0]       count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  tx_fifo_state_t        state;
`ifdef UART_FIFO_OVF_COUNT_EN
  logic [OVF_COUNT_W-1:0] overflow_count;

  modport master (
    output wr_data, wr_en, tx_busy,
    input  tx_data, tx_start, count, empty, full, overflow, state, overflow_count
  );
  modport slave (
    input  wr_data, wr_en, tx_busy,
    output tx_data, tx_start, count, empty, full, overflow, state, overflow_count
  );
`else
  modport master (
    output wr_data, wr_en, tx_busy,
    input  tx_data, tx_start, count, empty, full, overflow, state
  );
  modport slave (
    input  wr_data, wr_en, tx_busy,
    output tx_data, tx_start, count, empty, full, overflow, state
  );
`endif

endinterface

// File: rtl/sync_fifo.sv
// Circular FIFO: storage, wrapping pointers, occupancy counter and flags.
// rd_data is combinational from the head entry; a write at full succeeds only alongside a read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_ok, rd_ok;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO between UART receiver and transmitter, drained one frame per tx_start pulse.
// Optional feature macro: UART_FIFO_OVF_COUNT_EN (saturating overflow_count output).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FRAME_SIZE = UART_FRAME_SIZE_DEFAULT,
  parameter int DEPTH      = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  tx_fifo_state_t        state_q, state_d;
  logic [FRAME_SIZE-1:0] tx_data_q, tx_data_d;
  logic [FRAME_SIZE-1:0] rd_data;
  logic [ADDR_W:0]       count;
  logic                  empty, full;
  logic                  pop, tx_start, drop;
  logic                  overflow_q, overflow_d;

  sync_fifo #(
    .WIDTH (FRAME_SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .rd_en   (pop),
    .wr_data (bus.wr_data),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  // ARM ignores tx_busy to cover the transmitter's one-cycle lag in raising it.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    tx_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_busy) begin
          state_d   = START;
          pop       = 1'b1;
          tx_data_d = rd_data;
        end
      end
      START: begin
        tx_start = 1'b1;
        state_d  = ARM;
      end
      ARM:     state_d = HOLD;
      HOLD:    if (!bus.tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign drop       = bus.wr_en && full && !pop;
  assign overflow_d = overflow_q || drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef UART_FIFO_OVF_COUNT_EN
  logic [OVF_COUNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + OVF_COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= '0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign bus.overflow_count = ovf_cnt_q;
`endif

  assign bus.tx_start = tx_start && !rst;
  assign bus.tx_data  = tx_data_q;
  assign bus.count    = count;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle reference model built from frame queue and launch-timing rules.
// Build with UART_FIFO_OVF_COUNT_EN defined to also cover overflow_count.
module tb_uart_tx_fifo;
  localparam int W     = 8;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FRAME_SIZE(W), .DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.FRAME_SIZE(W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int             n_vec = 0;
  int             n_err = 0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   sent_q[$];
  logic [W-1:0]   m_tx_data;
  logic           m_start, m_ovf, m_wait;
  int             m_ovf_cnt;
  longint         cyc, m_gate;
  int             busy_cnt, busy_len, peak, starts;
  logic           force_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of the reference: a launch takes the queue head when the drainer is
  // free and tx_busy is low; after a launch tx_busy is ignored for the next two cycles.
  task automatic model_update();
    logic pop, acc;
    if (rst) begin
      exp_q.delete();
      m_tx_data = '0;
      m_start   = 1'b0;
      m_ovf     = 1'b0;
      m_ovf_cnt = 0;
      m_wait    = 1'b0;
    end else begin
      pop = !m_wait && (exp_q.size() > 0) && !bus.tx_busy;
      acc = bus.wr_en && ((exp_q.size() < DEPTH) || pop);
      if (m_wait && (cyc >= m_gate) && !bus.tx_busy) m_wait = 1'b0;
      if (pop) begin
        m_tx_data = exp_q.pop_front();
        m_wait    = 1'b1;
        m_gate    = cyc + 3;
      end
      if (acc) exp_q.push_back(bus.wr_data);
      if (bus.wr_en && !acc) begin
        m_ovf = 1'b1;
        if (m_ovf_cnt < 65535) m_ovf_cnt++;
      end
      m_start = pop;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    check("tx_start", bus.tx_start, m_start);
    check("count",    bus.count, exp_q.size());
    check("empty",    bus.empty, exp_q.size() == 0);
    check("full",     bus.full, exp_q.size() == DEPTH);
    check("overflow", bus.overflow, m_ovf);
    check("tx_data",  bus.tx_data, m_tx_data);
`ifdef UART_FIFO_OVF_COUNT_EN
    check("overflow_count", bus.overflow_count, m_ovf_cnt);
`endif
    if (bus.tx_start) begin
      sent_q.push_back(bus.tx_data);
      starts++;
    end
    if (int'(bus.count) > peak) peak = int'(bus.count);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
    if (busy_cnt > 0) busy_cnt--;
    if (bus.tx_start) busy_cnt = busy_len;
    bus.tx_busy = force_busy || (busy_cnt > 0);
  endtask

  task automatic write(input logic [W-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic set_busy(input logic b);
    force_busy  = b;
    bus.tx_busy = force_busy || (busy_cnt > 0);
  endtask

  task automatic wait_drained(input int limit);
    int n;
    n = 0;
    while (!(bus.empty && !m_wait && busy_cnt == 0) && n < limit) begin
      step();
      n++;
    end
    check("drain_timeout", n < limit, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] wr_list[$];
    int           n, s0;

    rst = 1'b1; bus.wr_en = 1'b0; bus.wr_data = '0; bus.tx_busy = 1'b0;
    force_busy = 1'b0; busy_cnt = 0; busy_len = 5; peak = 0; starts = 0;
    cyc = 0; m_gate = 0;
    repeat (2) step();
    rst = 1'b0;
    check("rst_count", bus.count, 0);
    check("rst_empty", bus.empty, 1'b1);
    check("rst_tx_data", bus.tx_data, 0);

    // single frame: count 0,1,0 and launch in cycle 2
    check("single_c0_count", bus.count, 0);
    write(8'hA5);
    check("single_c1_count", bus.count, 1);
    check("single_c1_start", bus.tx_start, 1'b0);
    step();
    check("single_c2_start", bus.tx_start, 1'b1);
    check("single_c2_data", bus.tx_data, 8'hA5);
    check("single_c2_count", bus.count, 0);
    wait_drained(100);

    // burst behind a slow transmitter
    busy_len = 100; peak = 0; sent_q.delete();
    for (int i = 1; i <= 5; i++) write(W'(i));
    wait_drained(1000);
    check("burst_peak", peak, 4);
    check("burst_n", sent_q.size(), 5);
    for (int i = 0; i < 5 && i < sent_q.size(); i++) check("burst_data", sent_q[i], i + 1);

    // overflow on the 17th write
    busy_len = 3;
    set_busy(1'b1);
    for (int i = 0; i < 17; i++) begin
      write(W'(8'h10 + i));
      if (i == 15) begin
        check("ovf_full", bus.full, 1'b1);
        check("ovf_not_yet", bus.overflow, 1'b0);
      end
    end
    check("ovf_flag", bus.overflow, 1'b1);
    check("ovf_count_held", bus.count, DEPTH);
`ifdef UART_FIFO_OVF_COUNT_EN
    check("ovf_counter_one", bus.overflow_count, 1);
`endif
    sent_q.delete();
    set_busy(1'b0);
    wait_drained(500);
    check("ovf_sent_n", sent_q.size(), 16);
    for (int i = 0; i < 16 && i < sent_q.size(); i++) check("ovf_sent_data", sent_q[i], 8'h10 + i);

    // write and pop together at full
    pulse_reset();
    set_busy(1'b1);
    for (int i = 0; i < 16; i++) write(W'(8'h40 + i));
    check("simul_full", bus.full, 1'b1);
    sent_q.delete();
    set_busy(1'b0);
    write(8'h99);
    check("simul_count", bus.count, DEPTH);
    check("simul_no_ovf", bus.overflow, 1'b0);
    wait_drained(500);
    check("simul_sent_n", sent_q.size(), 17);
    if (sent_q.size() == 17) check("simul_last", sent_q[16], 8'h99);

    // wrap-around with 1-in-3 writes and a fast transmitter
    busy_len = 2; peak = 0; sent_q.delete(); wr_list.delete();
    for (int i = 0; i < 40; i++) begin
      wr_list.push_back(W'($urandom_range(0, 255)));
      write(wr_list[i]);
      step();
      step();
    end
    wait_drained(500);
    check("wrap_peak_le_depth", peak <= DEPTH, 1'b1);
    check("wrap_sent_n", sent_q.size(), 40);
    for (int i = 0; i < 40 && i < sent_q.size(); i++) check("wrap_data", sent_q[i], wr_list[i]);

    // random traffic with random frame times, overflow included
    for (int i = 0; i < 400; i++) begin
      busy_len = $urandom_range(0, 12);
      if ($urandom_range(0, 1) == 1) write(W'($urandom_range(0, 255)));
      else step();
    end
    busy_len = 4;
    wait_drained(2000);

    // reset during HOLD
    pulse_reset();
    busy_len = 20;
    for (int i = 0; i < 6; i++) write(W'(8'hC0 + i));
    n = 0;
    while (!bus.tx_start && n < 50) begin
      step();
      n++;
    end
    check("rst_mid_launch_seen", bus.tx_start, 1'b1);
    step();
    step();
    check("rst_mid_in_hold", bus.state, uart_pkg::HOLD);
    pulse_reset();
    check("rst_mid_tx_start", bus.tx_start, 1'b0);
    check("rst_mid_count", bus.count, 0);
    check("rst_mid_empty", bus.empty, 1'b1);
    check("rst_mid_full", bus.full, 1'b0);
    check("rst_mid_overflow", bus.overflow, 1'b0);
    check("rst_mid_tx_data", bus.tx_data, 0);
    s0 = starts;
    repeat (40) step();
    check("rst_mid_no_start", starts - s0, 0);
    sent_q.delete();
    write(8'h5A);
    wait_drained(200);
    check("rst_mid_new_n", sent_q.size(), 1);
    if (sent_q.size() == 1) check("rst_mid_new_data", sent_q[0], 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffers received UART frames and paces them into the UART transmitter so back-to-back frames are never lost while the transmitter is busy. Sits between `uart_rx_control` (producer: `rx_data` / `rx_complete`) and `uart_tx_control` (consumer: `tx_data` / `tx_start`). Consists of a circular FIFO plus a drain state machine that issues one `tx_start` pulse per stored frame.

## Interface
- `FRAME_SIZE`, 8: bits per frame.
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥2.
- `ADDR_W`, $clog2(DEPTH): derived; not overridden.

- `clk`  in  1  system clock (100 MHz in the top level).
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `wr_data`  in  FRAME_SIZE  frame from the receiver.
- `wr_en`  in  1  single-cycle write strobe; connects to `rx_complete`.
- `tx_busy`  in  1  high while the transmitter is shifting a frame.
- `tx_data`  out  FRAME_SIZE  frame to the transmitter; registered.
- `tx_start`  out  1  single-cycle launch pulse.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `empty`, `full`  out  1  occupancy flags.
- `overflow`  out  1  sticky; a write was dropped.

## Operation
- **Storage:** `wr_ptr`/`rd_ptr`, ADDR_W bits each, wrap modulo DEPTH. Occupancy is held in an ADDR_W+1 counter. `full = (count == DEPTH)`, `empty = (count == 0)`.
- **Write:** accepted when `wr_en && (!full || pop)`.
  - `pop` is the read in the same cycle.
  - Write and pop in the same cycle leave `count` unchanged.
- **Drop:** `wr_en && full && !pop` drops the frame, leaves pointers untouched, and sets `overflow`. Only `rst` clears `overflow`.
- **Drain FSM** (states IDLE, START, ARM, HOLD):
  - IDLE→START when `!empty && !tx_busy`. On this transition: load `tx_data <= mem[rd_ptr]`, pop (`rd_ptr++`, `count--`).
  - START: `tx_start = 1` for exactly this cycle. Next state is ARM.
  - ARM: one cycle; `tx_busy` is ignored, covering the transmitter's one-cycle busy-assert lag. Next state is HOLD.
  - HOLD: exit to IDLE when `!tx_busy`.
- `tx_data` holds its value from START until the next START.
- Frames leave in write order. No frame is duplicated or skipped.

## Timing
- **Reset values:** `tx_data = 0`, `tx_start = 0`, `count = 0`, `empty = 1`, `full = 0`, `overflow = 0`. FSM = IDLE, pointers = 0.
- **Latency:** with `wr_en` in cycle 0, FIFO empty, FSM IDLE, and `tx_busy = 0`:
  - `count = 1` and `empty = 0` in cycle 1.
  - `tx_start = 1` and `tx_data` valid in cycle 2.
  - `count = 0` in cycle 2.
- **Spacing:** minimum spacing between `tx_start` pulses is 4 cycles (START, ARM, HOLD, IDLE) when `tx_busy` never rises. In practice spacing is the transmitter frame time plus 2 cycles.
- **Pointer wrap:** at DEPTH−1 the pointer wraps to 0 with no gap.
- **`tx_busy` high in IDLE:** blocks launch. This covers a transmitter still busy after reset.
- **Reset mid-operation:**
  - Contents are discarded and `tx_start` is forced to 0 in the reset cycle.
  - A frame already inside `uart_tx_control` finishes on its own.
  - After reset the FSM waits for `!tx_busy` before the next launch.

## Configuration
- **`UART_FIFO_OVF_COUNT_EN` defined:** adds output `overflow_count`, 16 bits.
  - Increments on every dropped write and saturates at 16'hFFFF.
  - Reset value is 0.
- **Not defined:** the port and counter are absent. `overflow` is the only drop indication.

## Structure
- **Package `uart_pkg`:**
  - `tx_fifo_state_t` enum {IDLE, START, ARM, HOLD}.
  - `UART_FRAME_SIZE_DEFAULT = 8`.
  - `OVF_COUNT_W = 16`.
- **Sub-module `sync_fifo`:** storage, pointers, count and flags, with ports `wr_en`/`rd_en`/`wr_data`/`rd_data`.
  - `uart_tx_fifo` wraps it with the drain FSM and overflow logic.
  - `rd_data` is combinational from `mem[rd_ptr]`.

## Test plan
- **Single frame:** reset, then `wr_data = 8'hA5` with `wr_en` in cycle 0 and `tx_busy = 0`. Expect `tx_start` only in cycle 2 with `tx_data = 8'hA5`, and `count` sequence 0, 1, 0.
- **Burst behind a busy transmitter:** write 0x01..0x05 on consecutive cycles while the transmitter model holds `tx_busy` high for 100 cycles after each start. Expect five `tx_start` pulses carrying 0x01..0x05 in order, and peak `count = 4`.
- **Overflow:** hold `tx_busy = 1` and write 17 frames 0x10..0x20. Expect:
  - `full = 1` after 16 writes.
  - The 17th frame (0x20) dropped and `overflow = 1`.
  - `overflow_count = 1` when the macro is defined.
  - After releasing `tx_busy`, exactly 0x10..0x1F are sent.
- **Simultaneous write and pop at full:** 16 frames stored, FSM IDLE, `tx_busy` falls, and `wr_en` (0x99) lands in the IDLE→START cycle. Expect `count` to stay at 16, no overflow, and 0x99 sent last.
- **Wrap-around:** 40 frames streamed with a 1-in-3 write duty and a fast `tx_busy` model. Expect output order identical to input and `count` never above DEPTH.
- **Reset mid-burst:** 6 frames queued and `rst` pulsed during HOLD. Expect all outputs at reset values the next cycle, and no `tx_start` until a new write arrives.
